mem_trace_uart_tx: RTL and testbench

Debug bus-trace transmitter for the yrv_mcu board tops. It captures memory-bus transactions (address + data) into a small FIFO and streams each one out over an auxiliary UART TX pin as a fixed 18-character ASCII line. This is the outbound counterpart of the aux UART boot receive path, so a host terminal can log MCU bus activity at full clock speed instead of reading it off the 7-segment display in slow-clock mode.

---
 rtl/mem_trace_pkg.sv | 38 +++
 rtl/mem_trace_uart_tx_if.sv | 24 ++
 rtl/uart_tx_byte.sv | 124 ++++++++++++
 rtl/mem_trace_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_mem_trace_uart_tx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_trace_pkg.sv
// Shared definitions for the memory-bus trace UART transmitter.
//   LINE_LEN / SEP_IDX / SEP_CHAR / EOL_CHAR : layout of one 18-byte ASCII line
//   trace_entry_t                            : one captured bus transaction
//   fmt_state_t / ser_state_t                : formatter and serializer FSM states
//   hex_ascii()                              : nibble -> uppercase ASCII hex digit
package mem_trace_pkg;

    localparam int         LINE_LEN = 18;
    localparam int         SEP_IDX  = 8;
    localparam logic [7:0] SEP_CHAR = 8'h20;
    localparam logic [7:0] EOL_CHAR = 8'h0A;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    typedef enum logic {
        FMT_IDLE,
        FMT_EMIT
    } fmt_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

    // 0-9 -> '0'-'9' (0x30-0x39), A-F -> 'A'-'F' (0x41-0x46)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/mem_trace_uart_tx_if.sv
// Trace bus: one-cycle strobe carrying a bus transaction's address and data.
//   trace_valid : address/data valid this cycle
//   trace_addr  : transaction address
//   trace_data  : transaction data
// master drives the bus (MCU top / bench), slave samples it (trace transmitter).
interface mem_trace_uart_tx_if;

    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    modport master (
        output trace_valid,
        output trace_addr,
        output trace_data
    );

    modport slave (
        input trace_valid,
        input trace_addr,
        input trace_data
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer with a valid/ready byte handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   byte_valid   : byte_data is offered
//   byte_data    : byte to send, d0 first
//   byte_ready   : byte accepted when byte_valid & byte_ready; high in idle and
//                  in the final cycle of the stop bit, so frames can abut
//   tx           : serial output, idle high
//   busy         : a frame is in progress
// Every bit, including start and stop, lasts exactly DIV clock cycles.
module uart_tx_byte
    import mem_trace_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_byte: DIV must be at least 2");
    end

    ser_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          bit_last;

    assign bit_last = (cnt_reg == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= SER_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        byte_ready = 1'b0;

        case (state_reg)
            SER_IDLE: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = SER_START;
                    cnt_next   = '0;
                    shift_next = byte_data;
                    tx_next    = 1'b0;
                end
            end
            SER_START: begin
                if (bit_last) begin
                    state_next = SER_DATA;
                    cnt_next   = '0;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SER_DATA: begin
                if (bit_last) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = SER_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SER_STOP: begin
                if (bit_last) begin
                    // Accepting here starts the next frame with no idle gap
                    byte_ready = 1'b1;
                    cnt_next   = '0;
                    if (byte_valid) begin
                        state_next = SER_START;
                        shift_next = byte_data;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = SER_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = SER_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != SER_IDLE);

endmodule

// File: rtl/mem_trace_uart_tx.sv
// Bus-trace transmitter: captures {addr, data} transactions into a small FIFO
// and streams each as "AAAAAAAA DDDDDDDD\n" (uppercase hex) over a UART pin.
//   clk, reset_n : clock, asynchronous active-low reset (discards all entries)
//   capture_en   : qualifies trace.trace_valid
//   trace        : trace bus (valid strobe, addr, data)
//   overflow_clr : synchronous clear of overflow (a same-cycle drop wins)
//   tx           : UART 8N1 output, idle high
//   busy         : FIFO non-empty, line being formatted, or frame in flight
//   overflow     : sticky, a transaction was dropped because the FIFO was full
module mem_trace_uart_tx
    import mem_trace_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                capture_en,
    mem_trace_uart_tx_if.slave  trace,
    input  logic                overflow_clr,
    output logic                tx,
    output logic                busy,
    output logic                overflow
);

    localparam int DIV = CLK_FREQUENCY / BAUD_RATE;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (DIV < 2) begin : g_div_check
        $error("mem_trace_uart_tx: CLK_FREQUENCY / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("mem_trace_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    // ---------------- FIFO ----------------
    trace_entry_t fifo_mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_reg, rd_ptr_reg;
    logic         fifo_ready_reg;
    logic         overflow_reg;
    logic         fifo_empty, fifo_full, push, drop, pop;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // Full is judged before any same-cycle pop, so such a push is dropped
    assign push = trace.trace_valid & capture_en & ~fifo_full;
    assign drop = trace.trace_valid & capture_en & fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= '{addr: trace.trace_addr, data: trace.trace_data};
        end
    end

    // fifo_ready_reg is a registered non-empty flag: it keeps the capture path
    // off the formatter's pop decision. It is one cycle stale after a pop, but
    // the formatter is then in EMIT for a whole line and never sees the stale value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_ready_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            fifo_ready_reg <= ~fifo_empty;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // ---------------- Formatter ----------------
    fmt_state_t  fmt_state_reg, fmt_state_next;
    logic [4:0]  char_idx_reg, char_idx_next;
    logic [63:0] line_reg, line_next;
    logic        byte_valid, byte_ready, ser_busy;
    logic [7:0]  byte_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmt_state_reg <= FMT_IDLE;
            char_idx_reg  <= '0;
            line_reg      <= '0;
        end else begin
            fmt_state_reg <= fmt_state_next;
            char_idx_reg  <= char_idx_next;
            line_reg      <= line_next;
        end
    end

    // line_reg holds {addr, data}; each accepted hex char shifts it left one
    // nibble, so the next digit is always line_reg[63:60].
    always_comb begin
        fmt_state_next = fmt_state_reg;
        char_idx_next  = char_idx_reg;
        line_next      = line_reg;
        pop            = 1'b0;
        byte_valid     = 1'b0;
        byte_data      = 8'h00;

        case (fmt_state_reg)
            FMT_IDLE: begin
                if (fifo_ready_reg) begin
                    pop            = 1'b1;
                    line_next      = fifo_mem[rd_ptr_reg[AW-1:0]];
                    char_idx_next  = '0;
                    fmt_state_next = FMT_EMIT;
                end
            end
            FMT_EMIT: begin
                byte_valid = 1'b1;
                if (char_idx_reg == 5'(SEP_IDX)) begin
                    byte_data = SEP_CHAR;
                end else if (char_idx_reg == 5'(LINE_LEN - 1)) begin
                    byte_data = EOL_CHAR;
                end else begin
                    byte_data = hex_ascii(line_reg[63:60]);
                end

                if (byte_ready) begin
                    if (char_idx_reg == 5'(LINE_LEN - 1)) begin
                        fmt_state_next = FMT_IDLE;
                    end else begin
                        char_idx_next = char_idx_reg + 1'b1;
                    end
                    if (char_idx_reg != 5'(SEP_IDX) && char_idx_reg != 5'(LINE_LEN - 1)) begin
                        line_next = {line_reg[59:0], 4'h0};
                    end
                end
            end
            default: begin
                fmt_state_next = FMT_IDLE;
            end
        endcase
    end

    // ---------------- Serializer ----------------
    uart_tx_byte #(
        .DIV (DIV)
    ) u_uart_tx_byte (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx),
        .busy       (ser_busy)
    );

    assign busy     = ~fifo_empty | (fmt_state_reg == FMT_EMIT) | ser_busy;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_mem_trace_uart_tx.sv
// Directed bench for mem_trace_uart_tx at DIV = 10 (1 MHz clock, 100 kbaud).
module tb_mem_trace_uart_tx;
    import mem_trace_pkg::*;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic capture_en = 1'b0;
    logic overflow_clr = 1'b0;
    logic tx, busy, overflow;

    mem_trace_uart_tx_if trace_bus ();

    always #5 clk = ~clk;

    mem_trace_uart_tx #(
        .CLK_FREQUENCY (1_000_000),
        .BAUD_RATE     (100_000),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .capture_en   (capture_en),
        .trace        (trace_bus),
        .overflow_clr (overflow_clr),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int push_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------- UART receiver: samples mid-bit on the falling clock edge ----------
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         rx_frame_err = 0;
    bit         rx_active = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1;
                rx_cnt = 0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % DIV == DIV / 2) begin
                if (rx_cnt / DIV >= 1 && rx_cnt / DIV <= 8) begin
                    rx_sh[rx_cnt / DIV - 1] = tx;
                end else if (rx_cnt / DIV == 9) begin
                    if (tx !== 1'b1) rx_frame_err++;
                    rx_q.push_back(rx_sh);
                    rx_active = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        trace_bus.trace_valid = 1'b1;
        trace_bus.trace_addr  = a;
        trace_bus.trace_data  = d;
        @(negedge clk);
        trace_bus.trace_valid = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic get_line(output logic [143:0] l);
        l = '0;
        for (int i = 0; i < LINE_LEN; i++) begin
            if (rx_q.size() > 0) l = {l[135:0], rx_q.pop_front()};
            else                 l = {l[135:0], 8'h00};
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start_q.delete();
    endtask

    logic [143:0] line;
    logic [143:0] exp_ovf [5];
    int           drop_cyc, first_cyc;
    bit           tx_low, busy_high, ovf_high;

    initial begin
        trace_bus.trace_valid = 1'b0;
        trace_bus.trace_addr  = '0;
        trace_bus.trace_data  = '0;
        exp_ovf[0] = "10000001 A0A00001\n";
        exp_ovf[1] = "10000002 A0A00002\n";
        exp_ovf[2] = "10000003 A0A00003\n";
        exp_ovf[3] = "10000004 A0A00004\n";
        exp_ovf[4] = "10000005 A0A00005\n";

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        reset_n = 1'b1;
        capture_en = 1'b1;
        repeat (2) @(negedge clk);

        // ---- single line ----
        clear_rx();
        push(32'h0000_1A2C, 32'hDEAD_BEEF);
        wait_idle("single_idle", 3000);
        drop_cyc = cyc;
        get_line(line);
        check("single_line", line, "00001A2C DEADBEEF\n");
        check("single_nbytes", rx_start_q.size(), 18);
        check("single_latency", rx_start_q[0] - push_cyc, 3);
        check("single_busy_len", drop_cyc - rx_start_q[0], 1800);
        check("single_no_gaps", rx_start_q[17] - rx_start_q[0], 1700);
        $display("txn single: line=\"00001A2C DEADBEEF\" start=%0d busy_drop=%0d", rx_start_q[0], drop_cyc);

        // ---- hex boundaries ----
        clear_rx();
        push(32'h0123_4567, 32'h89AB_CDEF);
        wait_idle("hex_idle", 3000);
        get_line(line);
        check("hex_line", line, "01234567 89ABCDEF\n");
        $display("txn hex: line checked, %0d bytes left", rx_q.size());

        // ---- capture_en gating ----
        clear_rx();
        capture_en = 1'b0;
        tx_low = 0; busy_high = 0; ovf_high = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            trace_bus.trace_valid = 1'b1;
            trace_bus.trace_addr  = 32'hFFFF_0000 + i;
            trace_bus.trace_data  = 32'h1234_0000 + i;
            @(negedge clk);
            trace_bus.trace_valid = 1'b0;
            if (tx !== 1'b1) tx_low = 1;
            if (busy !== 1'b0) busy_high = 1;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low = 1;
            if (busy !== 1'b0) busy_high = 1;
            if (overflow !== 1'b0) ovf_high = 1;
        end
        check("gate_tx_low", tx_low, 1'b0);
        check("gate_busy", busy_high, 1'b0);
        check("gate_overflow", ovf_high, 1'b0);
        check("gate_bytes", rx_q.size(), 0);
        $display("txn gating: 3 strobes ignored");
        capture_en = 1'b1;

        // ---- overflow: 7 back-to-back strobes, #6 dropped, #7 dropped with clr ----
        clear_rx();
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            trace_bus.trace_valid = 1'b1;
            trace_bus.trace_addr  = 32'h1000_0001 + i;
            trace_bus.trace_data  = 32'hA0A0_0001 + i;
            overflow_clr = (i == 6);
            @(negedge clk);
            if (i == 4) check("ovf_before_drop", overflow, 1'b0);
            if (i == 5) check("ovf_after_drop", overflow, 1'b1);
            if (i == 6) check("ovf_set_beats_clr", overflow, 1'b1);
        end
        trace_bus.trace_valid = 1'b0;
        overflow_clr = 1'b0;
        wait_idle("ovf_idle", 5 * 1800 + 500);
        for (int k = 0; k < 5; k++) begin
            get_line(line);
            check($sformatf("ovf_line%0d", k + 1), line, exp_ovf[k]);
        end
        check("ovf_no_extra", rx_q.size(), 0);
        check("ovf_sticky", overflow, 1'b1);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        $display("txn overflow: 5 lines sent, extra strobes dropped, overflow cleared");

        // ---- reset mid-frame: d3 of char 5 ('0', d3 = 0), 2 entries queued ----
        clear_rx();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            trace_bus.trace_valid = 1'b1;
            trace_bus.trace_addr  = 32'h1234_5078;
            trace_bus.trace_data  = 32'h5555_0000 + i;
            @(negedge clk);
            if (i == 0) first_cyc = cyc;
        end
        trace_bus.trace_valid = 1'b0;
        while (cyc < first_cyc + 3 + 545) @(negedge clk);
        check("rst_mid_tx_d3", tx, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_tx", tx, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        clear_rx();
        reset_n = 1'b1;
        tx_low = 0; busy_high = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low = 1;
            if (busy !== 1'b0) busy_high = 1;
        end
        check("rst_after_tx", tx_low, 1'b0);
        check("rst_after_busy", busy_high, 1'b0);
        check("rst_after_bytes", rx_q.size(), 0);
        $display("txn reset: mid-frame reset discarded line and queue");

        // ---- back-to-back lines ----
        clear_rx();
        @(negedge clk);
        trace_bus.trace_valid = 1'b1;
        trace_bus.trace_addr  = 32'hCAFE_0000;
        trace_bus.trace_data  = 32'h0000_0001;
        @(negedge clk);
        push_cyc = cyc;
        trace_bus.trace_addr  = 32'hCAFE_0004;
        trace_bus.trace_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        trace_bus.trace_valid = 1'b0;
        wait_idle("b2b_idle", 4500);
        drop_cyc = cyc;
        get_line(line);
        check("b2b_line1", line, "CAFE0000 00000001\n");
        get_line(line);
        check("b2b_line2", line, "CAFE0004 FFFFFFFF\n");
        check("b2b_latency", rx_start_q[0] - push_cyc, 3);
        check("b2b_gap", rx_start_q[18] - rx_start_q[17], 10 * DIV);
        check("b2b_total", drop_cyc - rx_start_q[0], 3600);
        $display("txn b2b: two lines, start=%0d busy_drop=%0d", rx_start_q[0], drop_cyc);

        check("framing", rx_frame_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
